// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment scanner: FSM state encoding,
// the space code and the character font.
package seg14_pkg;

    localparam int FONT_CHAR_W = 6;
    localparam int FONT_SEG_W  = 14;
    localparam int CODE_SPACE  = 36;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    // Segment order {a,b,c,d,e,f,g1,g2,h,i,j,k,l,m}; h/j upper diagonals,
    // i/l centre verticals, k/m lower diagonals.
    function automatic logic [FONT_SEG_W-1:0] font_glyph(input logic [FONT_CHAR_W-1:0] code);
        logic [FONT_SEG_W-1:0] g;
        case (code)
            6'd0:    g = 14'b11111100001100;
            6'd1:    g = 14'b01100000001000;
            6'd2:    g = 14'b11011011000000;
            6'd3:    g = 14'b11110001000000;
            6'd4:    g = 14'b01100111000000;
            6'd5:    g = 14'b10110111000000;
            6'd6:    g = 14'b10111111000000;
            6'd7:    g = 14'b11100000000000;
            6'd8:    g = 14'b11111111000000;
            6'd9:    g = 14'b11110111000000;
            6'd10:   g = 14'b11101111000000;
            6'd11:   g = 14'b11110001010010;
            6'd12:   g = 14'b10011100000000;
            6'd13:   g = 14'b11110000010010;
            6'd14:   g = 14'b10011110000000;
            6'd15:   g = 14'b10001110000000;
            6'd16:   g = 14'b10111101000000;
            6'd17:   g = 14'b01101111000000;
            6'd18:   g = 14'b10010000010010;
            6'd19:   g = 14'b01111000000000;
            6'd20:   g = 14'b00001110001001;
            6'd21:   g = 14'b00011100000000;
            6'd22:   g = 14'b01101100101000;
            6'd23:   g = 14'b01101100100001;
            6'd24:   g = 14'b11111100000000;
            6'd25:   g = 14'b11001111000000;
            6'd26:   g = 14'b11111100000001;
            6'd27:   g = 14'b11001111000001;
            6'd28:   g = 14'b10110111000000;
            6'd29:   g = 14'b10000000010010;
            6'd30:   g = 14'b01111100000000;
            6'd31:   g = 14'b00001100001100;
            6'd32:   g = 14'b01101100000101;
            6'd33:   g = 14'b00000000101101;
            6'd34:   g = 14'b00000000101010;
            6'd35:   g = 14'b10010000001100;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg14_font.sv
// Combinational character-code to segment-pattern lookup.
module seg14_font
    import seg14_pkg::*;
#(
    parameter int SEG_W  = 14,
    parameter int CHAR_W = 6
) (
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  segm
);

    logic [FONT_CHAR_W-1:0] idx;

    assign idx  = FONT_CHAR_W'(code);
    assign segm = SEG_W'(font_glyph(idx));

endmodule

// File: rtl/seg14_scan_ctrl.sv
// Multiplexed 14-segment display scanner with shadow/active character buffers.
// Define SEG14_SCROLL_EN to add the scroll_en input and the rotating digit offset.
//
// state | meaning
// IDLE  | display blanked, scanner parked at digit 0, waiting for en
// SCAN  | each digit held PRESCALE cycles, digits cycled one-hot
module seg14_scan_ctrl
    import seg14_pkg::*;
#(
`ifdef SEG14_SCROLL_EN
    parameter int SCROLL_FRAMES = 64,
`endif
    parameter int NUM_DIGITS    = 12,
    parameter int SEG_W         = 14,
    parameter int CHAR_W        = 6,
    parameter int PRESCALE      = 1000
) (
`ifdef SEG14_SCROLL_EN
    input  logic                          scroll_en,
`endif
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]             wr_data,
    input  logic                          commit,
    output logic                          commit_pending,
    output logic                          frame_start,
    output logic [NUM_DIGITS-1:0]         sel,
    output logic [SEG_W-1:0]              segm
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE = PW'(PRESCALE - 1);
    localparam logic [CHAR_W-1:0] SPACE = CHAR_W'(CODE_SPACE);

    state_t              state;
    logic [IW-1:0]       index;
    logic [IW-1:0]       index_nxt;
    logic [IW-1:0]       char_idx;
    logic [PW-1:0]       prescale_cnt;
    logic [CHAR_W-1:0]   shadow     [NUM_DIGITS];
    logic [CHAR_W-1:0]   active     [NUM_DIGITS];
    logic [CHAR_W-1:0]   shadow_nxt [NUM_DIGITS];
    logic [CHAR_W-1:0]   sel_char;
    logic [SEG_W-1:0]    seg_pat;
    logic                wr_hit;
    logic                start;
    logic                stop;
    logic                tc;
    logic                wrap;
    logic                apply;

    always_comb begin
        wr_hit = wr_en && (int'(wr_addr) < NUM_DIGITS);
        for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_nxt[i] = (wr_hit && (int'(wr_addr) == i)) ? wr_data : shadow[i];
        end
    end

    always_comb begin
        start = (state == IDLE) && en;
        stop  = (state == SCAN) && !en;
        tc    = (state == SCAN) && en && (prescale_cnt == LAST_PRE);
        wrap  = tc && (index == LAST_IDX);
        apply = commit_pending && (wrap || (state == IDLE));
        if (start || wrap) begin
            index_nxt = '0;
        end else if (tc) begin
            index_nxt = index + 1'b1;
        end else begin
            index_nxt = index;
        end
    end

`ifdef SEG14_SCROLL_EN
    localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(SCROLL_FRAMES - 1);

    logic [IW-1:0] offset;
    logic [IW-1:0] offset_nxt;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_nxt;
    logic [IW:0]   idx_sum;

    always_comb begin
        offset_nxt    = offset;
        frame_cnt_nxt = frame_cnt;
        if (apply) begin
            offset_nxt    = '0;
            frame_cnt_nxt = '0;
        end else if (wrap && scroll_en) begin
            if (frame_cnt == LAST_FRAME) begin
                frame_cnt_nxt = '0;
                offset_nxt    = (offset == LAST_IDX) ? '0 : offset + 1'b1;
            end else begin
                frame_cnt_nxt = frame_cnt + 1'b1;
            end
        end
        idx_sum  = {1'b0, index_nxt} + {1'b0, offset_nxt};
        char_idx = (idx_sum >= (IW+1)'(NUM_DIGITS)) ? IW'(idx_sum - (IW+1)'(NUM_DIGITS))
                                                    : IW'(idx_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset    <= '0;
            frame_cnt <= '0;
        end else begin
            offset    <= offset_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end
`else
    assign char_idx = index_nxt;
`endif

    // Look up the character that will be displayed after this edge, so a
    // commit landing on the wrap edge is already visible on digit 0.
    assign sel_char = apply ? shadow_nxt[char_idx] : active[char_idx];

    seg14_font #(
        .SEG_W  (SEG_W),
        .CHAR_W (CHAR_W)
    ) u_font (
        .code (sel_char),
        .segm (seg_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                shadow[i] <= SPACE;
                active[i] <= SPACE;
            end
        end else begin
            shadow <= shadow_nxt;
            if (apply) begin
                active <= shadow_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pending <= 1'b0;
        end else if (apply) begin
            commit_pending <= 1'b0;
        end else if (commit) begin
            commit_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            index        <= '0;
            prescale_cnt <= '0;
            sel          <= '0;
            segm         <= '0;
            frame_start  <= 1'b0;
        end else if (start || tc) begin
            state        <= SCAN;
            index        <= index_nxt;
            prescale_cnt <= '0;
            sel          <= {{(NUM_DIGITS-1){1'b0}}, 1'b1} << index_nxt;
            segm         <= seg_pat;
            frame_start  <= (index_nxt == '0);
        end else if (stop) begin
            state        <= IDLE;
            index        <= '0;
            prescale_cnt <= '0;
            sel          <= '0;
            segm         <= '0;
            frame_start  <= 1'b0;
        end else begin
            frame_start  <= 1'b0;
            if (state == SCAN) begin
                prescale_cnt <= prescale_cnt + 1'b1;
            end
        end
    end

endmodule
